alu_ctrl_seq: RTL and testbench

- Next-generation ALU control unit for the execute stage.
- Decodes the 2-bit ALUOp together with funct3 and funct7 into a 5-bit ALU/MDU operation code.
- Covers all of RV32I arithmetic (including immediate forms and branch compares) and, optionally, RV32M.
- Registered with valid/ready handshakes on both sides; sequences fixed-latency multiply/divide ops with a start pulse, a cycle counter and a busy indication used by the hazard unit to stall.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_ctrl_decode.sv | 73 +++++++
 rtl/alu_ctrl_seq.sv | 130 +++++++++++++
 tb/tb_alu_ctrl_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU control unit: operation codes,
// ALUOp and funct7 encodings, FSM state type and the base-integer funct3 map.
package alu_pkg;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_AND    = 5'd2;
   localparam logic [4:0] ALU_OR     = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_SLL    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_SLT    = 5'd8;
   localparam logic [4:0] ALU_SLTU   = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;
   localparam logic [4:0] ALU_ERR    = 5'd31;

   localparam logic [1:0] AOP_MEM    = 2'b00;
   localparam logic [1:0] AOP_BRANCH = 2'b01;
   localparam logic [1:0] AOP_RTYPE  = 2'b10;
   localparam logic [1:0] AOP_ITYPE  = 2'b11;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // funct3 meaning shared by R-type (funct7 = 0) and I-type ALU ops.
   function automatic logic [4:0] base_op(input logic [2:0] f3);
      logic [4:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp/funct3/funct7 into an ALU or MDU operation
// code, with illegal-encoding detection and multiply/divide classification.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter int ENABLE_M = 1
) (
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [4:0] ctrl,
   output logic       illegal,
   output logic       is_mdu,
   output logic       is_div
);

   // Illegal encodings force the ERR code so downstream never sees a stale op.
   always_comb begin
      ctrl    = ALU_ADD;
      illegal = 1'b0;
      is_mdu  = 1'b0;
      is_div  = 1'b0;
      case (alu_op)
         AOP_MEM: ctrl = ALU_ADD;
         AOP_BRANCH: begin
            case (funct3[2:1])
               2'b00:   ctrl = ALU_SUB;
               2'b10:   ctrl = ALU_SLT;
               2'b11:   ctrl = ALU_SLTU;
               default: illegal = 1'b1;
            endcase
         end
         AOP_RTYPE: begin
            if (funct7 == F7_BASE) begin
               ctrl = base_op(funct3);
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000)
                  ctrl = ALU_SUB;
               else if (funct3 == 3'b101)
                  ctrl = ALU_SRA;
               else
                  illegal = 1'b1;
            end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
               ctrl   = ALU_MUL | {2'b00, funct3};
               is_mdu = 1'b1;
               is_div = funct3[2];
            end else begin
               illegal = 1'b1;
            end
         end
         AOP_ITYPE: begin
            if (funct3 == 3'b001) begin
               if (funct7 == F7_BASE)
                  ctrl = ALU_SLL;
               else
                  illegal = 1'b1;
            end else if (funct3 == 3'b101) begin
               if (funct7 == F7_BASE)
                  ctrl = ALU_SRL;
               else if (funct7 == F7_ALT)
                  ctrl = ALU_SRA;
               else
                  illegal = 1'b1;
            end else begin
               ctrl = base_op(funct3);
            end
         end
      endcase
      if (illegal)
         ctrl = ALU_ERR;
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: accepts decode fields through a valid/ready
// handshake and sequences fixed-latency multiply/divide ops before presenting them.
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int ENABLE_M    = 1,
   parameter int MUL_LATENCY = 3,
   parameter int DIV_LATENCY = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kill,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] alu_ctrl,
   output logic       illegal,
   output logic       mdu_start,
   output logic       busy
);

   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CW      = $clog2(MAX_LAT) + 1;
   localparam logic [CW-1:0] MUL_LAT_C = CW'(MUL_LATENCY);
   localparam logic [CW-1:0] DIV_LAT_C = CW'(DIV_LATENCY);
   localparam logic [CW-1:0] ONE_C     = CW'(1);

   state_t        state;
   state_t        next_state;
   state_t        accept_state;
   logic [4:0]    ctrl_q;
   logic          illegal_q;
   logic          start_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] lat_sel;
   logic [4:0]    dec_ctrl;
   logic          dec_illegal;
   logic          dec_is_mdu;
   logic          dec_is_div;
   logic          accept;

   alu_ctrl_decode #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .alu_op  (alu_op),
      .funct3  (funct3),
      .funct7  (funct7),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .is_mdu  (dec_is_mdu),
      .is_div  (dec_is_div)
   );

   assign accept  = in_valid & in_ready & ~kill;
   assign lat_sel = dec_is_div ? DIV_LAT_C : MUL_LAT_C;

   // A single-cycle MDU op skips BUSY so its start pulse and result coincide.
   assign accept_state = (dec_is_mdu && lat_sel != ONE_C) ? ST_BUSY : ST_HOLD;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept)
               next_state = accept_state;
         end
         ST_BUSY: begin
            if (cnt_q == ONE_C)
               next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready)
               next_state = accept ? accept_state : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      if (kill)
         next_state = ST_IDLE;
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_BUSY: busy = 1'b1;
         ST_HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Result fields only move on accept, so they stay stable while held.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= ALU_ADD;
         illegal_q <= 1'b0;
         start_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         start_q <= accept & dec_is_mdu;
         if (accept) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            cnt_q     <= dec_is_mdu ? lat_sel : '0;
         end else if (state == ST_BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - ONE_C;
         end
      end
   end

   assign alu_ctrl  = ctrl_q;
   assign illegal   = illegal_q;
   assign mdu_start = start_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench: three parameterisations driven in lockstep, checked every
// cycle against a transaction-level model plus directed scenario checks.
module tb_alu_ctrl_seq;

   logic       clk;
   logic       rst;
   logic       kill;
   logic       inValid;
   logic       outReady;
   logic [1:0] aluOp;
   logic [2:0] funct3;
   logic [6:0] funct7;

   logic       inReady   [3];
   logic       outValid  [3];
   logic [4:0] aluCtrl   [3];
   logic       illegalO  [3];
   logic       mduStart  [3];
   logic       busyO     [3];

   int pEn  [3] = '{1, 1, 0};
   int pMul [3] = '{3, 1, 3};
   int pDiv [3] = '{32, 2, 32};

   int mBusy  [3];
   bit mHave  [3];
   bit mStart [3];
   bit mIll   [3];
   int mCtrl  [3];

   int totalChecks = 0;
   int badChecks   = 0;

   alu_ctrl_seq #(.ENABLE_M(1), .MUL_LATENCY(3), .DIV_LATENCY(32)) dut0 (
      .clk(clk), .rst(rst), .kill(kill), .in_valid(inValid), .in_ready(inReady[0]),
      .alu_op(aluOp), .funct3(funct3), .funct7(funct7), .out_valid(outValid[0]),
      .out_ready(outReady), .alu_ctrl(aluCtrl[0]), .illegal(illegalO[0]),
      .mdu_start(mduStart[0]), .busy(busyO[0]));

   alu_ctrl_seq #(.ENABLE_M(1), .MUL_LATENCY(1), .DIV_LATENCY(2)) dut1 (
      .clk(clk), .rst(rst), .kill(kill), .in_valid(inValid), .in_ready(inReady[1]),
      .alu_op(aluOp), .funct3(funct3), .funct7(funct7), .out_valid(outValid[1]),
      .out_ready(outReady), .alu_ctrl(aluCtrl[1]), .illegal(illegalO[1]),
      .mdu_start(mduStart[1]), .busy(busyO[1]));

   alu_ctrl_seq #(.ENABLE_M(0), .MUL_LATENCY(3), .DIV_LATENCY(32)) dut2 (
      .clk(clk), .rst(rst), .kill(kill), .in_valid(inValid), .in_ready(inReady[2]),
      .alu_op(aluOp), .funct3(funct3), .funct7(funct7), .out_valid(outValid[2]),
      .out_ready(outReady), .alu_ctrl(aluCtrl[2]), .illegal(illegalO[2]),
      .mdu_start(mduStart[2]), .busy(busyO[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed != expected) begin
         badChecks++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference decode written straight from the opcode tables.
   task automatic refDecode(input int en, input bit [1:0] op, input bit [2:0] f3,
                            input bit [6:0] f7, output int code, output bit ill,
                            output bit mdu, output bit dv);
      int baseTab [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
      code = 0; ill = 0; mdu = 0; dv = 0;
      if (op == 2'd0) begin
         code = 0;
      end else if (op == 2'd1) begin
         if (f3 <= 1) code = 1;
         else if (f3 <= 3) ill = 1;
         else if (f3 <= 5) code = 8;
         else code = 9;
      end else if (op == 2'd2) begin
         if (f7 == 7'd0) code = baseTab[f3];
         else if (f7 == 7'd32 && f3 == 0) code = 1;
         else if (f7 == 7'd32 && f3 == 5) code = 7;
         else if (f7 == 7'd1 && en != 0) begin
            code = 16 + int'(f3); mdu = 1; dv = (f3 >= 4);
         end else ill = 1;
      end else begin
         if (f3 == 1) begin
            if (f7 == 0) code = 5; else ill = 1;
         end else if (f3 == 5) begin
            if (f7 == 0) code = 6; else if (f7 == 32) code = 7; else ill = 1;
         end else code = baseTab[f3];
      end
      if (ill) code = 31;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mBusy[i] = 0; mHave[i] = 0; mStart[i] = 0; mIll[i] = 0; mCtrl[i] = 0;
      end
   endtask

   // Drives one cycle of inputs, checks every instance, then advances the model.
   task automatic applyStimulus(input bit iv, input bit [1:0] op, input bit [2:0] f3,
                                input bit [6:0] f7, input bit ordy, input bit kl);
      bit expIn, acc, ill, mdu, dv;
      int code, lat;
      inValid = iv; aluOp = op; funct3 = f3; funct7 = f7; outReady = ordy; kill = kl;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         expIn = (mBusy[i] == 0) && (!mHave[i] || ordy);
         checkOutput($sformatf("in_ready[%0d]", i), int'(inReady[i]), int'(expIn));
         checkOutput($sformatf("out_valid[%0d]", i), int'(outValid[i]), int'(mHave[i]));
         checkOutput($sformatf("busy[%0d]", i), int'(busyO[i]), int'(mBusy[i] > 0));
         checkOutput($sformatf("mdu_start[%0d]", i), int'(mduStart[i]), int'(mStart[i]));
         checkOutput($sformatf("alu_ctrl[%0d]", i), int'(aluCtrl[i]), mCtrl[i]);
         checkOutput($sformatf("illegal[%0d]", i), int'(illegalO[i]), int'(mIll[i]));
         if (kl) begin
            mHave[i] = 0; mBusy[i] = 0; mStart[i] = 0;
         end else begin
            acc = iv && expIn;
            mStart[i] = 0;
            if (mHave[i] && ordy) mHave[i] = 0;
            if (mBusy[i] > 0) begin
               mBusy[i]--;
               if (mBusy[i] == 0) mHave[i] = 1;
            end
            if (acc) begin
               refDecode(pEn[i], op, f3, f7, code, ill, mdu, dv);
               mCtrl[i] = code;
               mIll[i]  = ill;
               if (mdu) begin
                  mStart[i] = 1;
                  lat = dv ? pDiv[i] : pMul[i];
                  if (lat == 1) mHave[i] = 1;
                  else mBusy[i] = lat;
               end else begin
                  mHave[i] = 1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit [6:0] f7r;
      rst = 1'b1; kill = 1'b0; inValid = 1'b0; outReady = 1'b1;
      aluOp = 2'b00; funct3 = 3'b000; funct7 = 7'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();

      // Reset state, then a single R-type SUB.
      applyStimulus(1, 2'b10, 3'b000, 7'h20, 1, 0);
      checkOutput("sub_valid", int'(outValid[0]), 1);
      checkOutput("sub_ctrl", int'(aluCtrl[0]), 1);
      checkOutput("sub_busy", int'(busyO[0]), 0);

      // Back-to-back AND, SRAI, BLTU.
      applyStimulus(1, 2'b10, 3'b111, 7'h00, 1, 0);
      checkOutput("b2b_and", int'(aluCtrl[0]), 2);
      applyStimulus(1, 2'b11, 3'b101, 7'h20, 1, 0);
      checkOutput("b2b_srai", int'(aluCtrl[0]), 7);
      applyStimulus(1, 2'b01, 3'b110, 7'h00, 1, 0);
      checkOutput("b2b_bltu", int'(aluCtrl[0]), 9);
      applyStimulus(0, 2'b00, 3'b000, 7'h00, 1, 0);

      // MUL: start pulse, busy window, result; disabled-M instance flags illegal.
      applyStimulus(1, 2'b10, 3'b000, 7'h01, 1, 0);
      checkOutput("mul_start", int'(mduStart[0]), 1);
      checkOutput("mul_lat1_valid", int'(outValid[1]), 1);
      checkOutput("nom_ctrl", int'(aluCtrl[2]), 31);
      checkOutput("nom_illegal", int'(illegalO[2]), 1);
      repeat (3) applyStimulus(0, 2'b00, 3'b000, 7'h00, 1, 0);
      checkOutput("mul_valid", int'(outValid[0]), 1);
      checkOutput("mul_ctrl", int'(aluCtrl[0]), 16);

      // DIVU killed five cycles after accept.
      applyStimulus(1, 2'b10, 3'b101, 7'h01, 1, 0);
      repeat (4) applyStimulus(0, 2'b00, 3'b000, 7'h00, 1, 0);
      applyStimulus(1, 2'b10, 3'b000, 7'h00, 1, 1);
      checkOutput("kill_busy", int'(busyO[0]), 0);
      checkOutput("kill_valid", int'(outValid[0]), 0);
      checkOutput("kill_ready", int'(inReady[0]), 1);
      repeat (40) applyStimulus(0, 2'b00, 3'b000, 7'h00, 1, 0);

      // Illegal R-type alternate funct7 with funct3 111.
      applyStimulus(1, 2'b10, 3'b111, 7'h20, 1, 0);
      checkOutput("ill_ctrl", int'(aluCtrl[0]), 31);
      checkOutput("ill_flag", int'(illegalO[0]), 1);
      applyStimulus(0, 2'b00, 3'b000, 7'h00, 1, 0);

      // Backpressure: ADD held while XOR waits, then consumed and accepted together.
      applyStimulus(1, 2'b10, 3'b000, 7'h00, 0, 0);
      repeat (3) applyStimulus(1, 2'b10, 3'b100, 7'h00, 0, 0);
      checkOutput("bp_held_ctrl", int'(aluCtrl[0]), 0);
      checkOutput("bp_held_valid", int'(outValid[0]), 1);
      applyStimulus(1, 2'b10, 3'b100, 7'h00, 1, 0);
      checkOutput("bp_new_ctrl", int'(aluCtrl[0]), 4);
      checkOutput("bp_new_valid", int'(outValid[0]), 1);

      // Randomized traffic with occasional flushes.
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 3))
            0:       f7r = 7'h00;
            1:       f7r = 7'h20;
            2:       f7r = 7'h01;
            default: f7r = 7'($urandom);
         endcase
         applyStimulus(($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom), f7r,
                       ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
